// File: rtl/m_math_pkg.sv
// Shared definitions for the processor math library: divider state encoding,
// divide-by-zero quotient pattern and the default word width.
package m_math_pkg;

  localparam int M_WORD = 32;

  localparam logic [M_WORD-1:0] DIV_ZERO_QUOT = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

endpackage

// File: rtl/m_cneg.sv
// Combinational conditional two's-complement negate: out = en ? -in : in.
module m_cneg #(
  parameter int WIDTH = 32
) (
  input  logic             en,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);

  assign out = en ? ({WIDTH{1'b0}} - in) : in;

endmodule

// File: rtl/m_div_seq.sv
// Multi-cycle restoring divider (one quotient bit per cycle) with quotient/remainder outputs.
// M_DIV_SIGNED_EN enables two's-complement operation through the sign input and the FIX state.
module m_div_seq
  import m_math_pkg::*;
#(
  parameter int WIDTH = M_WORD
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sign,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             div_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  div_state_t       state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH-1:0] quo_reg, quo_next;
  logic [WIDTH-1:0] par_reg, par_next;
  logic [WIDTH-1:0] dvs_reg, dvs_next;
  logic [WIDTH-1:0] quot_reg, quot_next;
  logic [WIDTH-1:0] rem_reg, rem_next;
  logic             dz_reg, dz_next;

  logic [WIDTH-1:0] a_abs, b_abs, quo_fix, rem_fix;
  logic             neg_q_reg, neg_q_next, neg_r_reg, neg_r_next;

  // Partial remainder shifted left with the next dividend bit, and its trial subtraction.
  logic [WIDTH:0]   shifted, trial;
  logic [WIDTH-1:0] quo_step, par_step;

  assign shifted  = {par_reg, quo_reg[WIDTH-1]};
  assign trial    = shifted - {1'b0, dvs_reg};
  assign quo_step = {quo_reg[WIDTH-2:0], ~trial[WIDTH]};
  assign par_step = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];

`ifdef M_DIV_SIGNED_EN
  logic op_signed;
  assign op_signed  = sign;
  assign neg_q_next = (state_reg == IDLE) ? (op_signed & (a[WIDTH-1] ^ b[WIDTH-1])) : neg_q_reg;
  assign neg_r_next = (state_reg == IDLE) ? (op_signed & a[WIDTH-1]) : neg_r_reg;

  m_cneg #(.WIDTH(WIDTH)) u_abs_a (.en(op_signed & a[WIDTH-1]), .in(a),       .out(a_abs));
  m_cneg #(.WIDTH(WIDTH)) u_abs_b (.en(op_signed & b[WIDTH-1]), .in(b),       .out(b_abs));
  m_cneg #(.WIDTH(WIDTH)) u_fix_q (.en(neg_q_reg),              .in(quo_reg), .out(quo_fix));
  m_cneg #(.WIDTH(WIDTH)) u_fix_r (.en(neg_r_reg),              .in(par_reg), .out(rem_fix));
`else
  logic unused_sign;
  assign unused_sign = sign;
  assign neg_q_next  = 1'b0;
  assign neg_r_next  = 1'b0;
  assign a_abs       = a;
  assign b_abs       = b;
  assign quo_fix     = quo_reg;
  assign rem_fix     = par_reg;
`endif

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    quo_next   = quo_reg;
    par_next   = par_reg;
    dvs_next   = dvs_reg;
    quot_next  = quot_reg;
    rem_next   = rem_reg;
    dz_next    = dz_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (b == '0) begin
            state_next = DONE;
            quot_next  = {WIDTH{DIV_ZERO_QUOT[0]}};
            rem_next   = a;
            dz_next    = 1'b1;
          end else begin
            state_next = RUN;
            cnt_next   = CW'(WIDTH - 1);
            quo_next   = a_abs;
            par_next   = '0;
            dvs_next   = b_abs;
          end
        end
      end
      RUN: begin
        quo_next = quo_step;
        par_next = par_step;
        cnt_next = cnt_reg - 1'b1;
        if (cnt_reg == '0) begin
`ifdef M_DIV_SIGNED_EN
          state_next = FIX;
`else
          state_next = DONE;
          quot_next  = quo_step;
          rem_next   = par_step;
          dz_next    = 1'b0;
`endif
        end
      end
      FIX: begin
        state_next = DONE;
        quot_next  = quo_fix;
        rem_next   = rem_fix;
        dz_next    = 1'b0;
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      quo_reg   <= '0;
      par_reg   <= '0;
      dvs_reg   <= '0;
      neg_q_reg <= 1'b0;
      neg_r_reg <= 1'b0;
      quot_reg  <= '0;
      rem_reg   <= '0;
      dz_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      quo_reg   <= quo_next;
      par_reg   <= par_next;
      dvs_reg   <= dvs_next;
      neg_q_reg <= neg_q_next;
      neg_r_reg <= neg_r_next;
      quot_reg  <= quot_next;
      rem_reg   <= rem_next;
      dz_reg    <= dz_next;
    end
  end

  assign busy     = (state_reg != IDLE);
  assign done     = (state_reg == DONE);
  assign quot     = quot_reg;
  assign rem      = rem_reg;
  assign div_zero = dz_reg;

endmodule

// File: tb/tb_m_div_seq.sv
// Randomized scoreboard bench for m_div_seq; expectations come from native division.
module tb_m_div_seq;

  localparam int W = 32;
`ifdef M_DIV_SIGNED_EN
  localparam int LAT_NORM = W + 1;
`else
  localparam int LAT_NORM = W;
`endif

  logic         clk, rst_n, start, sign;
  logic [W-1:0] a, b;
  logic         busy, done, div_zero;
  logic [W-1:0] quot, rem;

  m_div_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sign(sign), .a(a), .b(b),
    .busy(busy), .done(done), .quot(quot), .rem(rem), .div_zero(div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           lat;
    int           t0;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: plain integer division, signed via 64-bit arithmetic.
  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic s);
    exp_t   e;
    longint sa, sb, lq, lr;
    e.a = av;
    e.b = bv;
    e.t0 = 0;
    if (bv == 0) begin
      e.q = '1; e.r = av; e.dz = 1'b1; e.lat = 0;
    end else begin
      e.dz = 1'b0; e.lat = LAT_NORM;
`ifdef M_DIV_SIGNED_EN
      if (s) begin
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        lq = sa / sb;
        lr = sa % sb;
        e.q = lq[W-1:0];
        e.r = lr[W-1:0];
      end else begin
        e.q = av / bv; e.r = av % bv;
      end
`else
      e.q = av / bv; e.r = av % bv;
`endif
    end
    return e;
  endfunction

  // Monitor: pop and compare on every done pulse.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done actual=1 required=0 quot=%0h rem=%0h", quot, rem);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk($sformatf("quot(%0h/%0h)", e.a, e.b), quot, e.q);
        chk($sformatf("rem(%0h/%0h)", e.a, e.b), rem, e.r);
        chk($sformatf("div_zero(%0h/%0h)", e.a, e.b), W'(div_zero), W'(e.dz));
        chk($sformatf("latency(%0h/%0h)", e.a, e.b), W'(cyc - e.t0), W'(e.lat));
        $display("txn a=%h b=%h quot=%h rem=%h dz=%0d lat=%0d", e.a, e.b, quot, rem, div_zero, cyc - e.t0);
      end
    end
  end

  task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic s, output int t0);
    exp_t e;
    int   guard;
    guard = 0;
    @(negedge clk);
    while (busy) begin
      @(negedge clk);
      guard++;
      if (guard > 200) begin
        chk("idle_timeout", W'(busy), '0);
        break;
      end
    end
    a = av; b = bv; sign = s; start = 1'b1;
    e = model(av, bv, s);
    e.t0 = cyc + 1;
    t0 = e.t0;
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", W'(busy), W'(1));
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while (sb_q.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_timeout", W'(sb_q.size()), '0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    logic [W-1:0] ra, rb;
    rst_n = 1'b0; start = 1'b0; sign = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", W'(busy), '0);
    chk("reset_done", W'(done), '0);
    chk("reset_quot", quot, '0);
    chk("reset_rem", rem, '0);
    chk("reset_div_zero", W'(div_zero), '0);
    rst_n = 1'b1;

    start_op(32'd100, 32'd7, 1'b0, t0);
    start_op(32'hFFFF_FFF9, 32'd2, 1'b1, t0);
    start_op(32'd5, 32'd0, 1'b0, t0);
    start_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, t0);
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, t0);
    start_op(32'd3, 32'd10, 1'b1, t0);

    // Second request mid-run must be dropped.
    start_op(32'd100, 32'd7, 1'b0, t0);
    while (cyc < t0 + 9) @(negedge clk);
    a = 32'd9; b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_during_ignored_start", W'(busy), W'(1));
    wait_drain();

    for (int i = 0; i < 40; i++) begin
      ra = $urandom();
      case ($urandom_range(0, 3))
        0: rb = '0;
        1: rb = W'($urandom_range(1, 15));
        2: rb = $urandom();
        default: rb = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'h8000_0000;
      endcase
      if ($urandom_range(0, 4) == 0) ra = 32'h8000_0000;
      start_op(ra, rb, 1'($urandom_range(0, 1)), t0);
    end
    wait_drain();

    // Asynchronous abort mid-operation.
    start_op(32'hFFFF_FFF0, 32'd3, 1'b1, t0);
    while (cyc < t0 + 14) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_busy", W'(busy), '0);
    chk("abort_done", W'(done), '0);
    chk("abort_quot", quot, '0);
    chk("abort_rem", rem, '0);
    chk("abort_div_zero", W'(div_zero), '0);
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    start_op(32'd12, 32'd4, 1'b0, t0);
    wait_drain();

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
